// File: rtl/jk_bank_sequencer_if.sv
// Command and observation bundle for jk_bank_sequencer.
// The master issues commands; the slave (sequencer) reports status and the JK bank drive/state.
interface jk_bank_sequencer_if #(
  parameter int unsigned Width = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [Width-1:0] cmd_data;
  logic             busy;
  logic             done;
  logic [Width-1:0] j;
  logic [Width-1:0] k;
  logic [Width-1:0] q;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, busy, done, j, k, q
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, busy, done, j, k, q
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving the J/K inputs of an internal WIDTH-bit JK flip-flop bank:
// clear/set/load/toggle in one cycle, or N-step up/down counting.
module jk_bank_sequencer #(
  parameter int unsigned Width = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  jk_bank_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StApply, StCount, StDone} state_e;

  localparam logic [2:0] OpNop    = 3'b000;
  localparam logic [2:0] OpClear  = 3'b001;
  localparam logic [2:0] OpSet    = 3'b010;
  localparam logic [2:0] OpLoad   = 3'b011;
  localparam logic [2:0] OpToggle = 3'b100;
  localparam logic [2:0] OpCntUp  = 3'b101;
  localparam logic [2:0] OpCntDn  = 3'b110;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [Width-1:0] data_q, data_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] j, k;
  logic [Width-1:0] up_mask, dn_mask;
  logic             accept;
  logic             is_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      data_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign is_count = (bus.cmd_op == OpCntUp) || (bus.cmd_op == OpCntDn);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = bus.cmd_op;
          data_d = bus.cmd_data;
          // A zero-step count degenerates to a single idle-drive APPLY cycle.
          if (is_count && (bus.cmd_data != '0)) begin
            state_d = StCount;
            cnt_d   = bus.cmd_data;
          end else begin
            state_d = StApply;
          end
        end
      end
      StApply: state_d = StDone;
      StCount: begin
        cnt_d = cnt_q - Width'(1);
        if (cnt_q == Width'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ripple-carry/borrow toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_mask    = '0;
    dn_mask    = '0;
    up_mask[0] = 1'b1;
    dn_mask[0] = 1'b1;
    for (int unsigned i = 1; i < Width; i++) begin
      up_mask[i] = up_mask[i-1] & q_q[i-1];
      dn_mask[i] = dn_mask[i-1] & ~q_q[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state_q == StApply) begin
      case (op_q)
        OpClear:  k = '1;
        OpSet:    j = '1;
        OpLoad: begin
          j = data_q;
          k = ~data_q;
        end
        OpToggle: begin
          j = data_q;
          k = data_q;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end else if (state_q == StCount) begin
      j = (op_q == OpCntUp) ? up_mask : dn_mask;
      k = j;
    end
  end

  // Per-bit JK characteristic: Q+ = J&~Q | ~K&Q.
  assign q_d = (j & ~q_q) | (~k & q_q);

  assign bus.cmd_ready = (state_q == StIdle) && rst_ni;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.j         = j;
  assign bus.k         = k;
  assign bus.q         = q_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer: table-driven single-step commands, hand sequences
// for counting, reset abort and held-valid, with a Done-driven scoreboard on the final Q.
module tb_jk_bank_sequencer;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [3:0] data;
    logic [3:0] exp_q;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  logic [3:0] sb_q[$];
  logic [3:0] sb_exp;
  vec_t vecs[9];

  jk_bank_sequencer_if #(.Width(4)) bus ();

  jk_bank_sequencer #(.Width(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Scoreboard: every Done must match the oldest outstanding expected Q.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_done_q", {28'd0, bus.q}, {28'd0, sb_exp});
      end
    end
  end

  // Precondition: at a negedge with the DUT idle. Ends at a negedge with the DUT idle.
  task automatic run_cmd(input vec_t v);
    check({v.name, "_ready_pre"}, {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_data  = v.data;
    sb_q.push_back(v.exp_q);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({v.name, "_j"}, {28'd0, bus.j}, {28'd0, v.exp_j});
    check({v.name, "_k"}, {28'd0, bus.k}, {28'd0, v.exp_k});
    check({v.name, "_busy_apply"}, {31'd0, bus.busy}, 32'd1);
    check({v.name, "_ready_apply"}, {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check({v.name, "_done"}, {31'd0, bus.done}, 32'd1);
    check({v.name, "_jk_done"}, {24'd0, bus.j, bus.k}, 32'd0);
    @(negedge clk);
    check({v.name, "_done_low"}, {31'd0, bus.done}, 32'd0);
    check({v.name, "_ready_post"}, {31'd0, bus.cmd_ready}, 32'd1);
    check({v.name, "_busy_post"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Counting checked against plain +1/-1 arithmetic; J/K must equal the bits that flip.
  task automatic run_count(input logic [2:0] op, input logic [3:0] n, input logic [3:0] start);
    logic [3:0] cur;
    logic [3:0] nxt;
    int         busy_cycles;
    cur         = start;
    busy_cycles = 0;
    check("cnt_ready_pre", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = n;
    sb_q.push_back((op == 3'b101) ? start + n : start - n);
    for (int s = 0; s < int'(n); s++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      nxt = (op == 3'b101) ? cur + 4'd1 : cur - 4'd1;
      check("cnt_q_step", {28'd0, bus.q}, {28'd0, cur});
      check("cnt_j", {28'd0, bus.j}, {28'd0, cur ^ nxt});
      check("cnt_k", {28'd0, bus.k}, {28'd0, cur ^ nxt});
      check("cnt_done_low", {31'd0, bus.done}, 32'd0);
      if (bus.busy === 1'b1) busy_cycles++;
      cur = nxt;
    end
    @(negedge clk);
    check("cnt_q_final", {28'd0, bus.q}, {28'd0, cur});
    check("cnt_done", {31'd0, bus.done}, 32'd1);
    if (bus.busy === 1'b1) busy_cycles++;
    check("cnt_busy_cycles", busy_cycles, int'(n) + 1);
    @(negedge clk);
    check("cnt_ready_post", {31'd0, bus.cmd_ready}, 32'd1);
    check("cnt_busy_post", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    vecs[0] = '{"load1010",  3'b011, 4'b1010, 4'b1010, 4'b1010, 4'b0101};
    vecs[1] = '{"set",       3'b010, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    vecs[2] = '{"toggle",    3'b100, 4'b0110, 4'b1001, 4'b0110, 4'b0110};
    vecs[3] = '{"clear",     3'b001, 4'b0101, 4'b0000, 4'b0000, 4'b1111};
    vecs[4] = '{"nop",       3'b000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{"load1110",  3'b011, 4'b1110, 4'b1110, 4'b1110, 4'b0001};
    vecs[6] = '{"load0001",  3'b011, 4'b0001, 4'b0001, 4'b0001, 4'b1110};
    vecs[7] = '{"cntup_n0",  3'b101, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    vecs[8] = '{"reserved",  3'b111, 4'b1011, 4'b1111, 4'b0000, 4'b0000};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_q", {28'd0, bus.q}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_jk", {24'd0, bus.j, bus.k}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);
    run_count(3'b101, 4'd3, 4'b1110);
    run_cmd(vecs[6]);
    run_count(3'b110, 4'd2, 4'b0001);
    run_cmd(vecs[7]);
    run_cmd(vecs[8]);

    // Reset during COUNT_UP N=10 after 4 steps: 1111 -> 0011, then abort.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b101;
    bus.cmd_data  = 4'd10;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_q_pre", {28'd0, bus.q}, {28'd0, 4'b0011});
    check("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_q", {28'd0, bus.q}, 32'd0);
    check("abort_jk", {24'd0, bus.j, bus.k}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_replay_q", {28'd0, bus.q}, 32'd0);
    check("abort_idle", {31'd0, bus.busy}, 32'd0);
    vecs[4].name = "nop_after_rst";
    run_cmd(vecs[4]);

    // Held valid with reserved opcode: accepted every third cycle, Q never moves.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b111;
    bus.cmd_data  = 4'b0101;
    repeat (3) sb_q.push_back(4'b0000);
    for (int c = 0; c < 9; c++) begin
      check("hold_q", {28'd0, bus.q}, 32'd0);
      check("hold_ready", {31'd0, bus.cmd_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
      check("hold_done", {31'd0, bus.done}, (c % 3 == 2) ? 32'd1 : 32'd0);
      check("hold_jk", {24'd0, bus.j, bus.k}, 32'd0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_idle", {31'd0, bus.busy}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller for a bank of JK flip-flops. It accepts one command at a time over a valid/ready handshake. For each command it sequences the J/K inputs of a WIDTH-bit JK register bank held inside the block, which supports clear, set, load, toggle and multi-cycle up/down counting. It is the sequencing layer that sits above the JK_FF storage elements, and its J/K drive is exported for observation.

## Interface
- WIDTH, 4: bits in the JK bank; also the width of Cmd_data and of the step counter.
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Cmd_valid  input  1  command present.
- Cmd_ready  output  1  block can accept a command (IDLE only).
- Cmd_op  input  3  opcode (see Operation).
- Cmd_data  input  WIDTH  load value, toggle mask, or step count N.
- Busy  output  1  command in progress (state != IDLE).
- Done  output  1  one-cycle completion pulse.
- J  output  WIDTH  J drive to bank this cycle.
- K  output  WIDTH  K drive to bank this cycle.
- Q  output  WIDTH  bank state.

## Operation
- JK bank per bit, on each rising edge: J,K = 00 hold, 01 clear, 10 set, 11 toggle.
- Handshake:
  - A command is accepted on an edge where Cmd_valid=1 and Cmd_ready=1.
  - Cmd_op and Cmd_data are captured on that edge. Inputs are ignored at all other times.
- Opcodes and the J/K each drives:
  - 000 NOP: J=K=0 for one cycle.
  - 001 CLEAR: J=0, K=all ones.
  - 010 SET: J=all ones, K=0.
  - 011 LOAD: J=D, K=~D.
  - 100 TOGGLE: J=K=D (mask).
  - 101 COUNT_UP, N=D steps: J[i]=K[i]=AND(Q[i-1:0]); bit 0 always toggles.
  - 110 COUNT_DN, N=D steps: J[i]=K[i]=AND(~Q[i-1:0]).
  - 111 reserved: executes as NOP.
- FSM states: IDLE, APPLY, COUNT, DONE.
  - IDLE -> APPLY on accept for opcodes 000–100 and 111.
  - IDLE -> APPLY on accept for count opcodes with N=0; J=K=0 in this case.
  - IDLE -> COUNT on accept for count opcodes with N>0. The step counter is loaded with N.
  - APPLY -> DONE after 1 cycle.
  - COUNT: drives the count J/K each cycle and decrements the step counter. Goes to DONE when the counter reaches 0, after exactly N cycles.
  - DONE -> IDLE after 1 cycle.
- Outputs by state:
  - J=K=0 in IDLE and DONE.
  - Done=1 only in DONE.
  - Cmd_ready=1 only in IDLE.
  - Busy=1 in APPLY, COUNT and DONE.
- Arithmetic:
  - Count wraps modulo 2^WIDTH: all-ones +1 -> 0; 0 -1 -> all-ones.
  - Maximum steps per command: 2^WIDTH-1.
- Reset (asynchronous, Reset=0):
  - Immediately sets state=IDLE, Q=0, step counter=0.
  - J=K=0, Done=0, Busy=0.
  - Cmd_ready=0 while Reset=0; Cmd_ready=1 from the first cycle after release.
- Reset mid-command aborts the command. No Done is produced and the command is not replayed.
- A Cmd_valid held high across DONE is not accepted until IDLE. Back-to-back commands therefore have a minimum spacing of 3 cycles for single-step opcodes.

## Timing
- Accept edge t0.
- Single-step ops:
  - J/K are valid during cycle t0..t1.
  - Q is updated at edge t1.
  - Done=1 during t1..t2.
  - Cmd_ready=1 again from t2.
- Count ops with N>0:
  - Q steps at edges t1..tN.
  - Done=1 during tN..tN+1.
  - Cmd_ready=1 from tN+1.
- Q changes only on edges where J/K are non-zero, or asynchronously on reset.

## Test plan
- Reset, then LOAD D=1010: Cmd_ready=1 after reset release. Q=1010 one edge after accept. Done pulses for exactly 1 cycle. Cmd_ready returns 2 cycles after accept.
- SET, then TOGGLE D=0110, then CLEAR: Q sequence 1111 -> 1001 -> 0000. J/K=1111/0000, 0110/0110, 0000/1111 in the respective APPLY cycles.
- LOAD 1110, then COUNT_UP D=3:
  - Q steps 1111 -> 0000 -> 0001, showing wrap.
  - Busy is high for 4 cycles.
  - Done asserts 3 edges after accept.
- LOAD 0001, then COUNT_DN D=2: Q steps 0000 -> 1111. COUNT_UP with D=0 leaves Q unchanged; Done follows 1 cycle after accept.
- Assert Reset low mid-COUNT_UP D=10 after 4 steps:
  - Q, J, K and Busy go to 0 without waiting for a clock edge.
  - No Done pulse.
  - After release, a NOP is accepted and completes normally.
- Hold Cmd_valid high with opcode 111 continuously: Q never changes. Done pulses every 3 cycles. Cmd_ready is low in every non-IDLE cycle.
